// File: rtl/vtg_pkg.sv
// Shared widths, sync bundle layout, default timing and the test-pattern helper
// for the video timing generator.
package vtg_pkg;

  localparam int unsigned CNT_W     = 12;
  localparam int unsigned LEN_W     = CNT_W + 1;
  localparam int unsigned MAX_TOTAL = 4096;
  localparam int unsigned SYNC_W    = 3;
  localparam int unsigned PIX_W     = 8;

  // Bit positions inside sync_out, as carried by the downstream delay lines
  localparam int unsigned SYNC_VS = 2;
  localparam int unsigned SYNC_HS = 1;
  localparam int unsigned SYNC_DE = 0;

  // Default timing: 640x480 at the standard porches
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam logic [PIX_W-1:0] PIX_GREEN = 8'h80;

  // Sync bundle payload; field order matches SYNC_VS/SYNC_HS/SYNC_DE
  typedef struct packed {
    logic vsync;
    logic hsync;
    logic de;
  } sync_t;

  // Bundle value outside sync pulses and outside active video
  function automatic sync_t sync_idle(input logic pol);
    sync_t s;
    s.vsync = ~pol;
    s.hsync = ~pol;
    s.de    = 1'b0;
    return s;
  endfunction

  // RGGB Bayer colour bars: red ramps with the column, blue is its inverse
  function automatic logic [PIX_W-1:0] bayer_pix(input logic [PIX_W-1:0] col,
                                                 input logic             row_odd);
    logic col_odd;
    col_odd = col[0];
    if (!row_odd) begin
      bayer_pix = col_odd ? PIX_GREEN : col;
    end else begin
      bayer_pix = col_odd ? ~col : PIX_GREEN;
    end
  endfunction

endpackage

// File: rtl/vtg_axis_counter.sv
// One timing axis: free-running counter over ACTIVE, FRONT, SYNC, BACK with
// segment decodes. Used once for the horizontal and once for the vertical axis.
module vtg_axis_counter
  import vtg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic [LEN_W-1:0] active_len,
  input  logic [LEN_W-1:0] fp_len,
  input  logic [LEN_W-1:0] sync_len,
  input  logic [LEN_W-1:0] bp_len,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             in_active,
  output logic             in_sync
);

  // Headroom so that summing four segment lengths can never overflow
  localparam int unsigned SUM_W = LEN_W + 2;

  logic [SUM_W-1:0] sync_start_c;
  logic [SUM_W-1:0] sync_end_c;
  logic [SUM_W-1:0] last_c;
  logic [SUM_W-1:0] count_ext_c;

  // Segment boundaries and decodes of the current count
  always_comb begin
    sync_start_c = SUM_W'(active_len) + SUM_W'(fp_len);
    sync_end_c   = sync_start_c + SUM_W'(sync_len);
    last_c       = sync_end_c + SUM_W'(bp_len) - SUM_W'(1);
    count_ext_c  = SUM_W'(count);
    wrap         = inc && (count_ext_c == last_c);
    in_active    = count_ext_c < SUM_W'(active_len);
    in_sync      = (count_ext_c >= sync_start_c) && (count_ext_c < sync_end_c);
  end

  // Advance on inc, returning to zero after the last back-porch position
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: horizontal/vertical counters, registered sync
// bundle {vsync,hsync,de}, pixel coordinates and a frame-start pulse.
// Optional macro VTG_TEST_PATTERN_EN adds pix_out carrying RGGB colour bars.
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter logic        SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [2:0]  sync_out,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        frame_start
`ifdef VTG_TEST_PATTERN_EN
  ,
  output logic [7:0]  pix_out
`endif
);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             v_wrap;
  logic             h_act;
  logic             v_act;
  logic             h_sync;
  logic             v_sync;
  logic             origin_q;

  sync_t            sync_c;
  logic [CNT_W-1:0] x_c;
  logic [CNT_W-1:0] y_c;
  logic             fs_c;

  vtg_axis_counter u_h_axis (
    .clk        (clk),
    .rst        (rst),
    .inc        (en),
    .active_len (LEN_W'(H_ACTIVE)),
    .fp_len     (LEN_W'(H_FP)),
    .sync_len   (LEN_W'(H_SYNC)),
    .bp_len     (LEN_W'(H_BP)),
    .count      (h_cnt),
    .wrap       (h_wrap),
    .in_active  (h_act),
    .in_sync    (h_sync)
  );

  // Vertical axis steps once per completed line
  vtg_axis_counter u_v_axis (
    .clk        (clk),
    .rst        (rst),
    .inc        (h_wrap),
    .active_len (LEN_W'(V_ACTIVE)),
    .fp_len     (LEN_W'(V_FP)),
    .sync_len   (LEN_W'(V_SYNC)),
    .bp_len     (LEN_W'(V_BP)),
    .count      (v_cnt),
    .wrap       (v_wrap),
    .in_active  (v_act),
    .in_sync    (v_sync)
  );

  // Tracks counters sitting at (0,0) so frame start needs no wide compare
  always_ff @(posedge clk) begin
    if (rst) begin
      origin_q <= 1'b1;
    end else if (v_wrap) begin
      origin_q <= 1'b1;
    end else if (en) begin
      origin_q <= 1'b0;
    end
  end

  // Decode counter state into the next output values
  always_comb begin
    sync_c       = sync_idle(SYNC_POL);
    x_c          = '0;
    y_c          = '0;
    fs_c         = 1'b0;
    sync_c.de    = h_act && v_act;
    sync_c.hsync = h_sync ? SYNC_POL : ~SYNC_POL;
    sync_c.vsync = v_sync ? SYNC_POL : ~SYNC_POL;
    if (sync_c.de) begin
      x_c  = h_cnt;
      y_c  = v_cnt;
      fs_c = origin_q;
    end
  end

  // Output registers: one clock behind the counters, frozen while en is low
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_out    <= sync_idle(SYNC_POL);
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else if (en) begin
      sync_out    <= sync_c;
      x           <= x_c;
      y           <= y_c;
      frame_start <= fs_c;
    end else begin
      frame_start <= 1'b0;
    end
  end

`ifdef VTG_TEST_PATTERN_EN
  logic [PIX_W-1:0] pix_c;

  // Test pattern value, blank outside active video
  always_comb begin
    pix_c = '0;
    if (sync_c.de) begin
      pix_c = bayer_pix(h_cnt[PIX_W-1:0], v_cnt[0]);
    end
  end

  // Pattern register, aligned with the sync bundle
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_out <= '0;
    end else if (en) begin
      pix_out <= pix_c;
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen with a tiny 14x7 raster, run with both
// sync polarities side by side. Optional macro VTG_TEST_PATTERN_EN adds pix_out checks.
module tb_video_timing_gen;

  localparam int HT = 14;
  localparam int VT = 7;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [2:0]  so_p, so_n;
  logic [11:0] x_p, y_p, x_n, y_n;
  logic        fs_p, fs_n;
`ifdef VTG_TEST_PATTERN_EN
  logic [7:0]  pix_p, pix_n;
`endif

  int checks   = 0;
  int failures = 0;
  int k        = 0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1)
  ) dut_p (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .sync_out    (so_p),
    .x           (x_p),
    .y           (y_p),
    .frame_start (fs_p)
`ifdef VTG_TEST_PATTERN_EN
    ,
    .pix_out     (pix_p)
`endif
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0)
  ) dut_n (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .sync_out    (so_n),
    .x           (x_n),
    .y           (y_n),
    .frame_start (fs_n)
`ifdef VTG_TEST_PATTERN_EN
    ,
    .pix_out     (pix_n)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s k=%0d got=0x%0h exp=0x%0h", tag, k, got, exp);
    end
  endtask

  // Expected outputs for output cycle kk of the 14x7 raster:
  // de on h 0..7 of v 0..3, hsync on h 10..11, vsync on v 5
  function automatic logic [2:0] exp_sync(input int kk, input logic pol);
    int h, v;
    logic de, hs, vs;
    h  = kk % HT;
    v  = (kk / HT) % VT;
    de = (h < 8) && (v < 4);
    hs = (h == 10) || (h == 11);
    vs = (v == 5);
    return {vs ? pol : ~pol, hs ? pol : ~pol, de};
  endfunction

  function automatic logic [11:0] exp_x(input int kk);
    int h, v;
    h = kk % HT;
    v = (kk / HT) % VT;
    return ((h < 8) && (v < 4)) ? 12'(h) : 12'd0;
  endfunction

  function automatic logic [11:0] exp_y(input int kk);
    int h, v;
    h = kk % HT;
    v = (kk / HT) % VT;
    return ((h < 8) && (v < 4)) ? 12'(v) : 12'd0;
  endfunction

  function automatic logic [7:0] exp_pix(input int kk);
    int h, v;
    logic [7:0] hv;
    h  = kk % HT;
    v  = (kk / HT) % VT;
    hv = 8'(h);
    if (!((h < 8) && (v < 4))) return 8'h00;
    if (v % 2 == 0) return (h % 2 == 0) ? hv : 8'h80;
    return (h % 2 == 0) ? 8'h80 : ~hv;
  endfunction

  task automatic check_all(input int kk, input bit frozen);
    logic fs_e;
    fs_e = frozen ? 1'b0 : ((kk % FT) == 0);
    check("sync_p", 32'(so_p), 32'(exp_sync(kk, 1'b1)));
    check("sync_n", 32'(so_n), 32'(exp_sync(kk, 1'b0)));
    check("x_p", 32'(x_p), 32'(exp_x(kk)));
    check("y_p", 32'(y_p), 32'(exp_y(kk)));
    check("x_n", 32'(x_n), 32'(exp_x(kk)));
    check("y_n", 32'(y_n), 32'(exp_y(kk)));
    check("fs_p", 32'(fs_p), 32'(fs_e));
    check("fs_n", 32'(fs_n), 32'(fs_e));
`ifdef VTG_TEST_PATTERN_EN
    check("pix_p", 32'(pix_p), 32'(exp_pix(kk)));
    check("pix_n", 32'(pix_n), 32'(exp_pix(kk)));
`endif
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_sync_p"}, 32'(so_p), 32'(3'b000));
    check({tag, "_sync_n"}, 32'(so_n), 32'(3'b110));
    check({tag, "_x"}, 32'(x_p), 32'd0);
    check({tag, "_y"}, 32'(y_p), 32'd0);
    check({tag, "_fs"}, 32'(fs_p), 32'd0);
`ifdef VTG_TEST_PATTERN_EN
    check({tag, "_pix"}, 32'(pix_p), 32'd0);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int fs_first, fs_second, vs_first, vs_len, de_line0, hs_line0, de_blank;
    fs_first  = -1;
    fs_second = -1;
    vs_first  = -1;
    vs_len    = 0;
    de_line0  = 0;
    hs_line0  = 0;
    de_blank  = 0;

    rst = 1'b1;
    en  = 1'b1;
    tick();
    tick();
    check_reset_state("reset");

    // Release reset and scan one full frame plus one line
    rst = 1'b0;
    for (int c = 0; c < FT + HT; c++) begin
      tick();
      check_all(k, 1'b0);
      if (fs_p) begin
        if (fs_first < 0) fs_first = k;
        else if (fs_second < 0) fs_second = k;
      end
      if (k < FT && so_p[2]) begin
        if (vs_first < 0) vs_first = k;
        vs_len++;
      end
      if (k < HT) begin
        de_line0 += int'(so_p[0]);
        hs_line0 += int'(so_p[1]);
      end
      if (k >= 4 * HT && k < FT) de_blank += int'(so_p[0]);
      k++;
    end
    check("fs_first", 32'(fs_first), 32'd0);
    check("fs_gap", 32'(fs_second - fs_first), 32'd98);
    check("vs_first", 32'(vs_first), 32'd70);
    check("vs_len", 32'(vs_len), 32'd14);
    check("de_line0", 32'(de_line0), 32'd8);
    check("hs_line0", 32'(hs_line0), 32'd2);
    check("de_blank_lines", 32'(de_blank), 32'd0);

    // Run to x=5 on an active line, then hold en low for 3 cycles
    for (int c = 0; c < HT && ((k - 1) % HT != 5); c++) begin
      tick();
      check_all(k, 1'b0);
      k++;
    end
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_all(k - 1, 1'b1);
      check("freeze_x", 32'(x_p), 32'd5);
    end
    en = 1'b1;
    tick();
    check_all(k, 1'b0);
    check("resume_x", 32'(x_p), 32'd6);
    k++;

    // Freeze on the frame-start cycle: pulse must drop while de/x/y hold
    for (int c = 0; c < FT && ((k - 1) % FT != 0); c++) begin
      tick();
      check_all(k, 1'b0);
      k++;
    end
    en = 1'b0;
    tick();
    check_all(k - 1, 1'b1);
    check("freeze_fs", 32'(fs_p), 32'd0);
    en = 1'b1;
    tick();
    check_all(k, 1'b0);
    k++;

    // Reset in the middle of the frame at y=2, x=3
    for (int c = 0; c < FT && ((k - 1) % FT != 2 * HT + 3); c++) begin
      tick();
      check_all(k, 1'b0);
      k++;
    end
    check("pre_rst_x", 32'(x_p), 32'd3);
    check("pre_rst_y", 32'(y_p), 32'd2);
    rst = 1'b1;
    tick();
    check_reset_state("midrst");
    rst = 1'b0;
    k = 0;
    tick();
    check_all(k, 1'b0);
    check("restart_fs", 32'(fs_p), 32'd1);
    check("restart_de", 32'(so_p[0]), 32'd1);
`ifdef VTG_TEST_PATTERN_EN
    check("pix_0_0", 32'(pix_p), 32'h00);
`endif
    k++;
    for (int c = 0; c < 15; c++) begin
      tick();
      check_all(k, 1'b0);
`ifdef VTG_TEST_PATTERN_EN
      if (k == 1) check("pix_1_0", 32'(pix_p), 32'h80);
      if (k == 15) check("pix_1_1", 32'(pix_p), 32'hFE);
`endif
      k++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
